// File: rtl/reservation_station_if.sv
// ============================================================================
// Module   : reservation_station_if
// Purpose  : Issue, CDB and ALU-dispatch bundle of the reservation station.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reservation_station_if #(
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
);
  logic               rs_full;
  logic               issue_enable;
  logic [OP_LOG-1:0]  issue_op;
  logic [31:0]        issue_Vj;
  logic               issue_Rj;
  logic [ROB_LOG-1:0] issue_Qj;
  logic [31:0]        issue_Vk;
  logic               issue_Rk;
  logic [ROB_LOG-1:0] issue_Qk;
  logic [31:0]        issue_Imm;
  logic [31:0]        issue_CurPc;
  logic [ROB_LOG-1:0] issue_RobId;
  logic               alu_cdb_valid;
  logic [ROB_LOG-1:0] alu_cdb_RobId;
  logic [31:0]        alu_cdb_value;
  logic               lsb_cdb_valid;
  logic [ROB_LOG-1:0] lsb_cdb_RobId;
  logic [31:0]        lsb_cdb_value;
  logic               alu_enable;
  logic [OP_LOG-1:0]  alu_op;
  logic [31:0]        alu_Vj;
  logic [31:0]        alu_Vk;
  logic [31:0]        alu_Imm;
  logic [31:0]        alu_CurPc;
  logic [ROB_LOG-1:0] alu_RobId;

  modport master (
    output issue_enable, issue_op, issue_Vj, issue_Rj, issue_Qj, issue_Vk,
           issue_Rk, issue_Qk, issue_Imm, issue_CurPc, issue_RobId,
           alu_cdb_valid, alu_cdb_RobId, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_RobId, lsb_cdb_value,
    input  rs_full, alu_enable, alu_op, alu_Vj, alu_Vk, alu_Imm, alu_CurPc,
           alu_RobId
  );

  modport slave (
    input  issue_enable, issue_op, issue_Vj, issue_Rj, issue_Qj, issue_Vk,
           issue_Rk, issue_Qk, issue_Imm, issue_CurPc, issue_RobId,
           alu_cdb_valid, alu_cdb_RobId, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_RobId, lsb_cdb_value,
    output rs_full, alu_enable, alu_op, alu_Vj, alu_Vk, alu_Imm, alu_CurPc,
           alu_RobId
  );
endinterface

`default_nettype wire

// File: rtl/reservation_station.sv
// ============================================================================
// Module   : reservation_station
// Purpose  : Holds non-memory ops until operands are ready, dispatches 1/cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int RS_LOG  = 4,
  parameter int ROB_LOG = 4,
  parameter int OP_LOG  = 6
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 rdy_i,
  input  wire logic                 rollback_i,
  reservation_station_if.slave      bus
);
  localparam int CW = RS_LOG + 1;

  logic [RS_SIZE-1:0] busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
  logic [OP_LOG-1:0]  op_q  [RS_SIZE];
  logic [OP_LOG-1:0]  op_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vj_d  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        vk_d  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        imm_d [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [31:0]        pc_d  [RS_SIZE];
  logic [ROB_LOG-1:0] qj_q  [RS_SIZE];
  logic [ROB_LOG-1:0] qj_d  [RS_SIZE];
  logic [ROB_LOG-1:0] qk_q  [RS_SIZE];
  logic [ROB_LOG-1:0] qk_d  [RS_SIZE];
  logic [ROB_LOG-1:0] rob_q [RS_SIZE];
  logic [ROB_LOG-1:0] rob_d [RS_SIZE];
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               alu_en_q, alu_en_d;
  logic [OP_LOG-1:0]  alu_op_q, alu_op_d;
  logic [31:0]        alu_vj_q, alu_vj_d, alu_vk_q, alu_vk_d;
  logic [31:0]        alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
  logic [ROB_LOG-1:0] alu_rob_q, alu_rob_d;

  logic [RS_LOG-1:0]  free_idx, rdy_idx;
  logic               has_free, has_rdy, do_ins, do_disp;

  function automatic logic cdb_hit(input logic v, input logic [ROB_LOG-1:0] t,
                                   input logic [ROB_LOG-1:0] q);
    return v && (t == q);
  endfunction

  // Descending scan leaves the lowest qualifying index as the final winner.
  always_comb begin
    free_idx = '0;
    rdy_idx  = '0;
    has_free = 1'b0;
    has_rdy  = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = RS_LOG'(i);
        has_free = 1'b1;
      end
      if (busy_q[i] && rj_q[i] && rk_q[i]) begin
        rdy_idx = RS_LOG'(i);
        has_rdy = 1'b1;
      end
    end
  end

  assign do_ins  = rdy_i && !rollback_i && bus.issue_enable && has_free;
  assign do_disp = rdy_i && !rollback_i && has_rdy;

  always_comb begin
    busy_d = busy_q; rj_d = rj_q; rk_d = rk_q;
    op_d = op_q; vj_d = vj_q; vk_d = vk_q; imm_d = imm_q; pc_d = pc_q;
    qj_d = qj_q; qk_d = qk_q; rob_d = rob_q;
    cnt_d     = cnt_q;
    alu_en_d  = 1'b0;
    alu_op_d  = alu_op_q;  alu_vj_d = alu_vj_q; alu_vk_d = alu_vk_q;
    alu_imm_d = alu_imm_q; alu_pc_d = alu_pc_q; alu_rob_d = alu_rob_q;
    if (rdy_i && rollback_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end else if (rdy_i) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i] && !rj_q[i]) begin
          if (cdb_hit(bus.alu_cdb_valid, bus.alu_cdb_RobId, qj_q[i])) begin
            vj_d[i] = bus.alu_cdb_value; rj_d[i] = 1'b1;
          end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_RobId, qj_q[i])) begin
            vj_d[i] = bus.lsb_cdb_value; rj_d[i] = 1'b1;
          end
        end
        if (busy_q[i] && !rk_q[i]) begin
          if (cdb_hit(bus.alu_cdb_valid, bus.alu_cdb_RobId, qk_q[i])) begin
            vk_d[i] = bus.alu_cdb_value; rk_d[i] = 1'b1;
          end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_RobId, qk_q[i])) begin
            vk_d[i] = bus.lsb_cdb_value; rk_d[i] = 1'b1;
          end
        end
      end
      // Dispatch reads the registered operands; a wakeup this edge waits a cycle.
      if (do_disp) begin
        busy_d[rdy_idx] = 1'b0;
        alu_en_d  = 1'b1;
        alu_op_d  = op_q[rdy_idx];
        alu_vj_d  = vj_q[rdy_idx];
        alu_vk_d  = vk_q[rdy_idx];
        alu_imm_d = imm_q[rdy_idx];
        alu_pc_d  = pc_q[rdy_idx];
        alu_rob_d = rob_q[rdy_idx];
      end
      if (do_ins) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = bus.issue_op;
        imm_d[free_idx]  = bus.issue_Imm;
        pc_d[free_idx]   = bus.issue_CurPc;
        rob_d[free_idx]  = bus.issue_RobId;
        qj_d[free_idx]   = bus.issue_Qj;
        qk_d[free_idx]   = bus.issue_Qk;
        vj_d[free_idx]   = bus.issue_Vj;
        rj_d[free_idx]   = bus.issue_Rj;
        vk_d[free_idx]   = bus.issue_Vk;
        rk_d[free_idx]   = bus.issue_Rk;
        if (!bus.issue_Rj) begin
          if (cdb_hit(bus.alu_cdb_valid, bus.alu_cdb_RobId, bus.issue_Qj)) begin
            vj_d[free_idx] = bus.alu_cdb_value; rj_d[free_idx] = 1'b1;
          end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_RobId, bus.issue_Qj)) begin
            vj_d[free_idx] = bus.lsb_cdb_value; rj_d[free_idx] = 1'b1;
          end
        end
        if (!bus.issue_Rk) begin
          if (cdb_hit(bus.alu_cdb_valid, bus.alu_cdb_RobId, bus.issue_Qk)) begin
            vk_d[free_idx] = bus.alu_cdb_value; rk_d[free_idx] = 1'b1;
          end else if (cdb_hit(bus.lsb_cdb_valid, bus.lsb_cdb_RobId, bus.issue_Qk)) begin
            vk_d[free_idx] = bus.lsb_cdb_value; rk_d[free_idx] = 1'b1;
          end
        end
      end
      cnt_d = cnt_q + CW'(do_ins) - CW'(do_disp);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0; rj_q <= '0; rk_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i] <= '0; vj_q[i] <= '0; vk_q[i] <= '0; imm_q[i] <= '0;
        pc_q[i] <= '0; qj_q[i] <= '0; qk_q[i] <= '0; rob_q[i] <= '0;
      end
      cnt_q     <= '0;
      alu_en_q  <= 1'b0;
      alu_op_q  <= '0; alu_vj_q <= '0; alu_vk_q <= '0;
      alu_imm_q <= '0; alu_pc_q <= '0; alu_rob_q <= '0;
    end else begin
      busy_q <= busy_d; rj_q <= rj_d; rk_q <= rk_d;
      op_q <= op_d; vj_q <= vj_d; vk_q <= vk_d; imm_q <= imm_d;
      pc_q <= pc_d; qj_q <= qj_d; qk_q <= qk_d; rob_q <= rob_d;
      cnt_q     <= cnt_d;
      alu_en_q  <= alu_en_d;
      alu_op_q  <= alu_op_d;  alu_vj_q <= alu_vj_d; alu_vk_q <= alu_vk_d;
      alu_imm_q <= alu_imm_d; alu_pc_q <= alu_pc_d; alu_rob_q <= alu_rob_d;
    end
  end

  // One slot of margin absorbs the instruction issue already has in flight.
  assign bus.rs_full    = (cnt_q >= CW'(RS_SIZE - 1));
  assign bus.alu_enable = alu_en_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_Vj     = alu_vj_q;
  assign bus.alu_Vk     = alu_vk_q;
  assign bus.alu_Imm    = alu_imm_q;
  assign bus.alu_CurPc  = alu_pc_q;
  assign bus.alu_RobId  = alu_rob_q;

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Directed self-checking bench for reservation_station.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reservation_station;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  reservation_station_if #(.ROB_LOG(4), .OP_LOG(6)) bus ();

  reservation_station #(.RS_SIZE(16), .RS_LOG(4), .ROB_LOG(4), .OP_LOG(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy_i      (rdy),
    .rollback_i (rollback),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_enable = 1'b0; bus.issue_op = '0; bus.issue_Vj = '0; bus.issue_Rj = 1'b0;
    bus.issue_Qj = '0; bus.issue_Vk = '0; bus.issue_Rk = 1'b0; bus.issue_Qk = '0;
    bus.issue_Imm = '0; bus.issue_CurPc = '0; bus.issue_RobId = '0;
    bus.alu_cdb_valid = 1'b0; bus.alu_cdb_RobId = '0; bus.alu_cdb_value = '0;
    bus.lsb_cdb_valid = 1'b0; bus.lsb_cdb_RobId = '0; bus.lsb_cdb_value = '0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] vj, input logic rj,
                       input logic [3:0] qj, input logic [31:0] vk, input logic rk,
                       input logic [3:0] qk, input logic [3:0] rob);
    bus.issue_enable = 1'b1; bus.issue_op = op;
    bus.issue_Vj = vj; bus.issue_Rj = rj; bus.issue_Qj = qj;
    bus.issue_Vk = vk; bus.issue_Rk = rk; bus.issue_Qk = qk;
    bus.issue_Imm = 32'h100 + 32'(rob); bus.issue_CurPc = 32'h1000 + 32'(rob);
    bus.issue_RobId = rob;
  endtask

  task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_RobId = tag; bus.alu_cdb_value = val;
  endtask

  task automatic lsb_cdb(input logic [3:0] tag, input logic [31:0] val);
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_RobId = tag; bus.lsb_cdb_value = val;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_en",    32'(bus.alu_enable), 32'd0);
    chk("rst_full",  32'(bus.rs_full),    32'd0);
    chk("rst_vj",    bus.alu_Vj,          32'd0);
    chk("rst_rob",   32'(bus.alu_RobId),  32'd0);
    rst_n = 1'b1;
    tick();

    // Ready insert
    issue(6'd1, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
    tick(); idle();
    chk("ins_en0",   32'(bus.alu_enable), 32'd0);
    tick();
    chk("ins_en1",   32'(bus.alu_enable), 32'd1);
    chk("ins_vj",    bus.alu_Vj,          32'd5);
    chk("ins_vk",    bus.alu_Vk,          32'd7);
    chk("ins_rob",   32'(bus.alu_RobId),  32'd3);
    chk("ins_op",    32'(bus.alu_op),     32'd1);
    chk("ins_pc",    bus.alu_CurPc,       32'h1003);
    chk("ins_imm",   bus.alu_Imm,         32'h103);
    tick();
    chk("ins_en2",   32'(bus.alu_enable), 32'd0);
    chk("ins_full",  32'(bus.rs_full),    32'd0);

    // Wakeup through the ALU bus; unrelated LSB tag leaves it waiting
    issue(6'd2, 32'd0, 1'b0, 4'd4, 32'd11, 1'b1, 4'd0, 4'd6);
    tick(); idle();
    lsb_cdb(4'd5, 32'h55);
    tick(); idle();
    chk("wk_lsb5",   32'(bus.alu_enable), 32'd0);
    alu_cdb(4'd4, 32'hDEAD);
    tick(); idle();
    chk("wk_edge",   32'(bus.alu_enable), 32'd0);
    tick();
    chk("wk_en",     32'(bus.alu_enable), 32'd1);
    chk("wk_vj",     bus.alu_Vj,          32'hDEAD);
    chk("wk_vk",     bus.alu_Vk,          32'd11);
    chk("wk_rob",    32'(bus.alu_RobId),  32'd6);
    tick();
    chk("wk_done",   32'(bus.alu_enable), 32'd0);

    // Same-cycle forwarding from LSB, then both buses on one tag (ALU wins)
    issue(6'd3, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd2, 4'd7);
    lsb_cdb(4'd2, 32'd9);
    tick(); idle();
    tick();
    chk("fw_en",     32'(bus.alu_enable), 32'd1);
    chk("fw_vk",     bus.alu_Vk,          32'd9);
    chk("fw_rob",    32'(bus.alu_RobId),  32'd7);
    issue(6'd4, 32'd0, 1'b0, 4'd8, 32'd2, 1'b1, 4'd0, 4'd9);
    alu_cdb(4'd8, 32'hA);
    lsb_cdb(4'd8, 32'hB);
    tick(); idle();
    tick();
    chk("fw2_en",    32'(bus.alu_enable), 32'd1);
    chk("fw2_vj",    bus.alu_Vj,          32'hA);
    tick();

    // Fill 15 entries; entries 2 and 7 wait on tag 9, the rest on tag 10
    for (int i = 0; i < 15; i++) begin
      issue(6'd5, 32'd0, 1'b0, (i == 2 || i == 7) ? 4'd9 : 4'd10,
            32'd0, 1'b1, 4'd0, 4'(i));
      tick();
      if (i == 13) chk("full_14", 32'(bus.rs_full), 32'd0);
    end
    idle();
    chk("full_15",   32'(bus.rs_full),    32'd1);
    chk("full_noen", 32'(bus.alu_enable), 32'd0);
    alu_cdb(4'd9, 32'h99);
    tick(); idle();
    chk("pri_wake",  32'(bus.alu_enable), 32'd0);
    chk("pri_full",  32'(bus.rs_full),    32'd1);
    tick();
    chk("pri_en1",   32'(bus.alu_enable), 32'd1);
    chk("pri_rob1",  32'(bus.alu_RobId),  32'd2);
    chk("pri_vj1",   bus.alu_Vj,          32'h99);
    chk("pri_drop",  32'(bus.rs_full),    32'd0);
    tick();
    chk("pri_en2",   32'(bus.alu_enable), 32'd1);
    chk("pri_rob2",  32'(bus.alu_RobId),  32'd7);
    tick();
    chk("pri_en3",   32'(bus.alu_enable), 32'd0);

    // Rollback with simultaneous issue and CDB traffic
    rollback = 1'b1;
    issue(6'd6, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd12);
    alu_cdb(4'd10, 32'h10);
    tick(); idle(); rollback = 1'b0;
    chk("rb_en",     32'(bus.alu_enable), 32'd0);
    chk("rb_full",   32'(bus.rs_full),    32'd0);
    tick();
    chk("rb_noins",  32'(bus.alu_enable), 32'd0);
    alu_cdb(4'd10, 32'h10);
    tick(); idle();
    tick();
    chk("rb_nowake", 32'(bus.alu_enable), 32'd0);

    // Freeze: ready entry waits while rdy is low
    issue(6'd7, 32'h13, 1'b1, 4'd0, 32'h31, 1'b1, 4'd0, 4'd13);
    tick(); idle();
    rdy = 1'b0;
    tick();
    chk("frz_0",     32'(bus.alu_enable), 32'd0);
    tick();
    chk("frz_1",     32'(bus.alu_enable), 32'd0);
    rdy = 1'b1;
    tick();
    chk("frz_en",    32'(bus.alu_enable), 32'd1);
    chk("frz_rob",   32'(bus.alu_RobId),  32'd13);
    chk("frz_vj",    bus.alu_Vj,          32'h13);

    // Asynchronous reset between edges
    issue(6'd8, 32'h44, 1'b1, 4'd0, 32'h45, 1'b1, 4'd0, 4'd14);
    tick(); idle();
    tick();
    chk("ar_pre",    32'(bus.alu_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_en",     32'(bus.alu_enable), 32'd0);
    chk("ar_rob",    32'(bus.alu_RobId),  32'd0);
    chk("ar_vj",     bus.alu_Vj,          32'd0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_post",   32'(bus.alu_enable), 32'd0);
    chk("ar_full",   32'(bus.rs_full),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
